// File: rtl/call_stack_ctrl.sv
// Call/return stack controller: sequences push/pop handshakes to an external
// stack memory, tracks occupancy and raises sticky error flags.
module call_stack_ctrl #(
  parameter int DEPTH  = 8,
  parameter int DATA_W = 32
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         call_req,
  input  logic [DATA_W-1:0]            ret_addr_in,
  input  logic                         ret_req,
  input  logic                         clr_err,
  output logic                         busy,
  output logic                         done,
  output logic                         ret_valid,
  output logic [DATA_W-1:0]            ret_addr_out,
  output logic [$clog2(DEPTH+1)-1:0]   sp,
  output logic                         overflow,
  output logic                         underflow,
  output logic                         conflict,
  output logic                         read_en,
  output logic                         write_en,
  output logic [DATA_W-1:0]            data_in,
  input  logic [DATA_W-1:0]            data_out
);

  localparam int SP_W = $clog2(DEPTH + 1);
  localparam logic [SP_W-1:0] SP_FULL = SP_W'(DEPTH);
  localparam logic [SP_W-1:0] SP_ZERO = '0;
  localparam logic [SP_W-1:0] SP_ONE  = SP_W'(1);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PUSH = 3'd1,
    POP  = 3'd2,
    WAIT = 3'd3,
    FIN  = 3'd4
  } state_t;

  state_t            state;
  state_t            next_state;
  logic [SP_W-1:0]   sp_next;
  logic              done_next;
  logic              valid_next;
  logic              latch_addr;
  logic              capture;
  logic              set_ovf;
  logic              set_udf;
  logic              set_cnf;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state decode; outputs are derived from the next state so they are registered
  always_comb begin
    next_state = state;
    sp_next    = sp;
    done_next  = 1'b0;
    valid_next = 1'b0;
    latch_addr = 1'b0;
    capture    = 1'b0;
    set_ovf    = 1'b0;
    set_udf    = 1'b0;
    set_cnf    = 1'b0;
    case (state)
      IDLE: begin
        if (call_req && ret_req) begin
          set_cnf    = 1'b1;
          next_state = FIN;
        end else if (call_req) begin
          if (sp == SP_FULL) begin
            set_ovf    = 1'b1;
            done_next  = 1'b1;
            next_state = FIN;
          end else begin
            latch_addr = 1'b1;
            next_state = PUSH;
          end
        end else if (ret_req) begin
          if (sp == SP_ZERO) begin
            set_udf    = 1'b1;
            done_next  = 1'b1;
            next_state = FIN;
          end else begin
            next_state = POP;
          end
        end else begin
          next_state = IDLE;
        end
      end
      PUSH: begin
        if (sp != SP_FULL) begin
          sp_next = sp + SP_ONE;
        end else begin
          sp_next = sp;
        end
        done_next  = 1'b1;
        next_state = FIN;
      end
      POP: begin
        if (sp != SP_ZERO) begin
          sp_next = sp - SP_ONE;
        end else begin
          sp_next = sp;
        end
        next_state = WAIT;
      end
      WAIT: begin
        capture    = 1'b1;
        done_next  = 1'b1;
        valid_next = 1'b1;
        next_state = FIN;
      end
      FIN: begin
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Registered outputs, occupancy and sticky flags (a set beats a clear)
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy         <= 1'b0;
      done         <= 1'b0;
      ret_valid    <= 1'b0;
      read_en      <= 1'b0;
      write_en     <= 1'b0;
      data_in      <= '0;
      ret_addr_out <= '0;
      sp           <= '0;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
      conflict     <= 1'b0;
    end else begin
      busy      <= (next_state != IDLE);
      done      <= done_next;
      ret_valid <= valid_next;
      read_en   <= (next_state == POP);
      write_en  <= (next_state == PUSH);
      data_in   <= latch_addr ? ret_addr_in : '0;
      if (capture) begin
        ret_addr_out <= data_out;
      end else begin
        ret_addr_out <= ret_addr_out;
      end
      sp        <= sp_next;
      overflow  <= set_ovf | (overflow  & ~clr_err);
      underflow <= set_udf | (underflow & ~clr_err);
      conflict  <= set_cnf | (conflict  & ~clr_err);
    end
  end

endmodule

// File: tb/tb_call_stack_ctrl.sv
// Directed bench for call_stack_ctrl with a behavioural stack memory attached.
module tb_call_stack_ctrl;
  localparam int DEPTH  = 8;
  localparam int DATA_W = 32;
  localparam int SP_W   = $clog2(DEPTH + 1);

  logic              clk = 1'b0;
  logic              rst_n, call_req, ret_req, clr_err;
  logic [DATA_W-1:0] ret_addr_in, ret_addr_out, data_in, data_out;
  logic              busy, done, ret_valid, overflow, underflow, conflict;
  logic              read_en, write_en;
  logic [SP_W-1:0]   sp;

  int checks   = 0;
  int failures = 0;

  logic [DATA_W-1:0] mem [DEPTH];
  int                ptr;

  always #5 clk = ~clk;

  call_stack_ctrl #(.DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst_n(rst_n), .call_req(call_req), .ret_addr_in(ret_addr_in),
    .ret_req(ret_req), .clr_err(clr_err), .busy(busy), .done(done),
    .ret_valid(ret_valid), .ret_addr_out(ret_addr_out), .sp(sp),
    .overflow(overflow), .underflow(underflow), .conflict(conflict),
    .read_en(read_en), .write_en(write_en), .data_in(data_in), .data_out(data_out)
  );

  // Stack memory: synchronous write, read data valid the cycle after read_en
  always @(posedge clk) begin
    if (!rst_n) begin
      ptr      <= 0;
      data_out <= '0;
    end else if (write_en && ptr < DEPTH) begin
      mem[ptr] <= data_in;
      ptr      <= ptr + 1;
    end else if (read_en && ptr > 0) begin
      data_out <= mem[ptr-1];
      ptr      <= ptr - 1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; call_req = 1'b0; ret_req = 1'b0; clr_err = 1'b0; ret_addr_in = '0;
    tick(); tick();
    rst_n = 1'b1;
  endtask

  // Present a request for one edge (edge N); returns #1 into cycle N+1
  task automatic issue(input logic c, input logic r, input logic [DATA_W-1:0] a);
    call_req = c; ret_req = r; ret_addr_in = a;
    tick();
    call_req = 1'b0; ret_req = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0b exp=0", busy); end
    checks++; if (sp !== 4'd0) begin failures++; $display("FAIL reset_sp got=%0d exp=0", sp); end
    checks++; if ({done, ret_valid, read_en, write_en} !== 4'b0000) begin failures++; $display("FAIL reset_pulses got=%b exp=0000", {done, ret_valid, read_en, write_en}); end
    checks++; if ({overflow, underflow, conflict} !== 3'b000) begin failures++; $display("FAIL reset_flags got=%b exp=000", {overflow, underflow, conflict}); end
    checks++; if ({data_in, ret_addr_out} !== 64'd0) begin failures++; $display("FAIL reset_data got=%h exp=0", {data_in, ret_addr_out}); end
  endtask

  task automatic test_single_call();
    do_reset();
    issue(1'b1, 1'b0, 32'h100);
    checks++; if ({busy, write_en, read_en, done} !== 4'b1100) begin failures++; $display("FAIL call_n1_ctl got=%b exp=1100", {busy, write_en, read_en, done}); end
    checks++; if (data_in !== 32'h100) begin failures++; $display("FAIL call_n1_data got=%h exp=100", data_in); end
    tick();
    checks++; if ({write_en, done, sp} !== {1'b0, 1'b1, 4'd1}) begin failures++; $display("FAIL call_n2 got we=%b done=%b sp=%0d exp we=0 done=1 sp=1", write_en, done, sp); end
    tick();
    checks++; if ({busy, done} !== 2'b00) begin failures++; $display("FAIL call_n3 got busy=%b done=%b exp 0 0", busy, done); end
  endtask

  task automatic test_call_ret();
    do_reset();
    issue(1'b1, 1'b0, 32'hA); tick(); tick();
    issue(1'b1, 1'b0, 32'hB); tick(); tick();
    checks++; if (sp !== 4'd2) begin failures++; $display("FAIL push2_sp got=%0d exp=2", sp); end
    issue(1'b0, 1'b1, 32'h0);
    checks++; if ({read_en, write_en, busy} !== 3'b101) begin failures++; $display("FAIL pop_n1 got=%b exp=101", {read_en, write_en, busy}); end
    tick();
    checks++; if ({read_en, done, sp} !== {1'b0, 1'b0, 4'd1}) begin failures++; $display("FAIL pop_n2 got re=%b done=%b sp=%0d exp 0 0 1", read_en, done, sp); end
    tick();
    checks++; if ({done, ret_valid, ret_addr_out} !== {2'b11, 32'hB}) begin failures++; $display("FAIL pop_b got done=%b vld=%b addr=%h exp 1 1 b", done, ret_valid, ret_addr_out); end
    tick();
    checks++; if ({ret_valid, busy, ret_addr_out} !== {2'b00, 32'hB}) begin failures++; $display("FAIL pop_hold got vld=%b busy=%b addr=%h exp 0 0 b", ret_valid, busy, ret_addr_out); end
    issue(1'b0, 1'b1, 32'h0); tick(); tick();
    checks++; if ({done, ret_valid, ret_addr_out, sp} !== {2'b11, 32'hA, 4'd0}) begin failures++; $display("FAIL pop_a got done=%b vld=%b addr=%h sp=%0d exp 1 1 a 0", done, ret_valid, ret_addr_out, sp); end
    tick();
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      issue(1'b1, 1'b0, 32'h200 + 32'(i)); tick(); tick();
    end
    checks++; if (sp !== 4'd8) begin failures++; $display("FAIL fill_sp got=%0d exp=8", sp); end
    issue(1'b1, 1'b0, 32'h300);
    checks++; if ({write_en, done, overflow, sp} !== {3'b011, 4'd8}) begin failures++; $display("FAIL ovf got we=%b done=%b ovf=%b sp=%0d exp 0 1 1 8", write_en, done, overflow, sp); end
    tick();
    clr_err = 1'b1; tick(); clr_err = 1'b0;
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL ovf_clr got=%b exp=0", overflow); end
  endtask

  task automatic test_underflow();
    do_reset();
    issue(1'b0, 1'b1, 32'h0);
    checks++; if ({read_en, underflow, done, ret_valid} !== 4'b0110) begin failures++; $display("FAIL udf got=%b exp=0110", {read_en, underflow, done, ret_valid}); end
    tick();
    checks++; if ({underflow, ret_valid, sp} !== {2'b10, 4'd0}) begin failures++; $display("FAIL udf_after got udf=%b vld=%b sp=%0d exp 1 0 0", underflow, ret_valid, sp); end
  endtask

  task automatic test_conflict();
    do_reset();
    issue(1'b1, 1'b0, 32'h55); tick(); tick();
    issue(1'b1, 1'b1, 32'h66);
    checks++; if ({conflict, write_en, read_en, busy, sp} !== {4'b1001, 4'd1}) begin failures++; $display("FAIL cnf got c=%b we=%b re=%b busy=%b sp=%0d exp 1 0 0 1 1", conflict, write_en, read_en, busy, sp); end
    tick();
    clr_err = 1'b1; issue(1'b1, 1'b1, 32'h77); clr_err = 1'b0;
    checks++; if (conflict !== 1'b1) begin failures++; $display("FAIL cnf_set_wins got=%b exp=1", conflict); end
    tick();
    clr_err = 1'b1; tick(); clr_err = 1'b0;
    checks++; if ({conflict, sp} !== {1'b0, 4'd1}) begin failures++; $display("FAIL cnf_clr got c=%b sp=%0d exp 0 1", conflict, sp); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    issue(1'b1, 1'b0, 32'h42);
    ret_req = 1'b1; tick(); ret_req = 1'b0;
    checks++; if ({read_en, write_en, done} !== 3'b001) begin failures++; $display("FAIL drop_n2 got=%b exp=001", {read_en, write_en, done}); end
    tick(); tick();
    checks++; if ({read_en, busy, sp} !== {2'b00, 4'd1}) begin failures++; $display("FAIL drop_idle got re=%b busy=%b sp=%0d exp 0 0 1", read_en, busy, sp); end
  endtask

  task automatic test_reset_mid_pop();
    do_reset();
    issue(1'b1, 1'b0, 32'h99); tick(); tick();
    issue(1'b0, 1'b1, 32'h0);
    checks++; if (read_en !== 1'b1) begin failures++; $display("FAIL rpop_pre got=%b exp=1", read_en); end
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    checks++; if ({busy, read_en, done, sp} !== {3'b000, 4'd0}) begin failures++; $display("FAIL rpop got busy=%b re=%b done=%b sp=%0d exp 0 0 0 0", busy, read_en, done, sp); end
    tick();
    checks++; if ({done, ret_valid, busy} !== 3'b000) begin failures++; $display("FAIL rpop_after got=%b exp=000", {done, ret_valid, busy}); end
  endtask

  initial begin
    rst_n = 1'b0; call_req = 1'b0; ret_req = 1'b0; clr_err = 1'b0; ret_addr_in = '0;
    test_reset();
    test_single_call();
    test_call_ret();
    test_overflow();
    test_underflow();
    test_conflict();
    test_back_to_back();
    test_reset_mid_pop();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
